// File: rtl/trivium_core.sv
// Trivium stream-cipher core: 80-bit key, 80-bit IV, 288-bit state, serial keystream out.
// Latency: Kvld 1 cycle after Krdy; first keystream bit 1153 cycles after IV accept (289 with TRIVIUM_FASTINIT_EN).
// Backpressure: none on the stream itself; EN=0 freezes every register and output, Krdy/Drdy are ignored while busy.
//
// Ports:
//   CLK     rising-edge clock            RST     synchronous active-high reset
//   Kin     key, K1 = Kin[0]             Din     IV, IV1 = Din[0]
//   Krdy    key strobe                   Drdy    IV strobe (needs a loaded key)
//   EncDec  unused (Trivium is symmetric) EN     global clock enable
//   Dout    keystream bit (0 when idle)  Dvld    Dout is valid
//   BSY     IV accepted, warm-up/stream  Kvld    one-cycle pulse, key latched
// Build option: define TRIVIUM_FASTINIT_EN to run warm-up at 4 rounds per cycle.

module trivium_core #(
   parameter int unsigned OUT_BITS = 128
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic [79:0] Kin,
   input  logic [79:0] Din,
   output logic        Dout,
   input  logic        Krdy,
   input  logic        Drdy,
   input  logic        EncDec,
   input  logic        EN,
   output logic        BSY,
   output logic        Kvld,
   output logic        Dvld
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_INIT   = 2'd1,
      S_STREAM = 2'd2
   } state_t;

   localparam logic [15:0] LP_OUT_BITS = 16'(OUT_BITS);
`ifdef TRIVIUM_FASTINIT_EN
   localparam logic [10:0] LP_INIT_LAST = 11'd287;   // 288 cycles x 4 rounds
`else
   localparam logic [10:0] LP_INIT_LAST = 11'd1151;  // 1152 cycles x 1 round
`endif

   // State bit s(k) lives at r_s[k-1].
   state_t        r_state;
   logic [79:0]   r_key;
   logic          r_key_loaded;
   logic [287:0]  r_s;
   logic [10:0]   r_wcnt;
   logic [15:0]   r_scnt;
   logic          r_dout;
   logic          r_dvld;
   logic          r_bsy;
   logic          r_kvld;

   logic          w_z;
   logic [287:0]  w_next1;
   logic [287:0]  w_init_next;
   logic          w_unused;

   // Keystream bit of the current state.
   function automatic logic f_z(input logic [287:0] s);
      return s[65] ^ s[92] ^ s[161] ^ s[176] ^ s[242] ^ s[287];
   endfunction

   // One Trivium round: three feedback taps, then each register shifts by one.
   function automatic logic [287:0] f_next(input logic [287:0] s);
      logic t1;
      logic t2;
      logic t3;
      t1 = s[65]  ^ s[92]  ^ (s[90]  & s[91])  ^ s[170];
      t2 = s[161] ^ s[176] ^ (s[174] & s[175]) ^ s[263];
      t3 = s[242] ^ s[287] ^ (s[285] & s[286]) ^ s[68];
      return {s[286:177], t2, s[175:93], t1, s[91:0], t3};
   endfunction

   assign w_z     = f_z(r_s);
   assign w_next1 = f_next(r_s);

`ifdef TRIVIUM_FASTINIT_EN
   assign w_init_next = f_next(f_next(f_next(w_next1)));
`else
   assign w_init_next = w_next1;
`endif

   // Encryption and decryption share the keystream, so the mode pin has no effect.
   assign w_unused = EncDec;

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state      <= S_IDLE;
         r_key        <= '0;
         r_key_loaded <= 1'b0;
         r_s          <= '0;
         r_wcnt       <= '0;
         r_scnt       <= '0;
         r_dout       <= 1'b0;
         r_dvld       <= 1'b0;
         r_bsy        <= 1'b0;
         r_kvld       <= 1'b0;
      end else if (EN) begin
         r_kvld <= 1'b0;
         case (r_state)
            S_IDLE: begin
               // Key has priority; a simultaneous Drdy is picked up on a later cycle.
               if (Krdy) begin
                  r_key        <= Kin;
                  r_key_loaded <= 1'b1;
                  r_kvld       <= 1'b1;
               end else if (Drdy && r_key_loaded) begin
                  // s1..s80 = key, s94..s173 = IV, s286..s288 = 1, rest 0.
                  r_s     <= {3'b111, 108'd0, 4'd0, Din, 13'd0, r_key};
                  r_wcnt  <= '0;
                  r_scnt  <= '0;
                  r_bsy   <= 1'b1;
                  r_state <= S_INIT;
               end
            end
            S_INIT: begin
               r_s    <= w_init_next;
               r_wcnt <= r_wcnt + 11'd1;
               if (r_wcnt == LP_INIT_LAST) begin
                  r_state <= S_STREAM;
               end
            end
            S_STREAM: begin
               if (r_scnt == LP_OUT_BITS) begin
                  // All bits delivered: drop Dvld and BSY together.
                  r_state <= S_IDLE;
                  r_dout  <= 1'b0;
                  r_dvld  <= 1'b0;
                  r_bsy   <= 1'b0;
               end else begin
                  r_dout <= w_z;
                  r_dvld <= 1'b1;
                  r_s    <= w_next1;
                  r_scnt <= r_scnt + 16'd1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign Dout = r_dout;
   assign Dvld = r_dvld;
   assign BSY  = r_bsy;
   assign Kvld = r_kvld;

endmodule

// File: tb/tb_trivium_core.sv
// Bench for trivium_core: directed key/IV loads, scoreboard-checked keystream.
// Expected bits come from a published test vector plus a bench-side Trivium model.
// Outputs are sampled #1 after the clock edge (stimulus) and on the falling edge (monitor).

module tb_trivium_core;

   localparam int OUT_N = 128;
`ifdef TRIVIUM_FASTINIT_EN
   localparam int INIT_CYC = 288;
`else
   localparam int INIT_CYC = 1152;
`endif

   logic        CLK = 1'b0;
   logic        RST = 1'b1;
   logic [79:0] Kin = '0;
   logic [79:0] Din = '0;
   logic        Krdy = 1'b0;
   logic        Drdy = 1'b0;
   logic        EncDec = 1'b0;
   logic        EN = 1'b0;
   logic        Dout;
   logic        BSY;
   logic        Kvld;
   logic        Dvld;

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int acc_cyc;
   int n;

   bit   exp_q[$];
   logic en_q = 1'b0;
   logic rst_q = 1'b1;
   bit   ms[1:288];

   localparam logic [79:0] K1  = 80'h0123_4567_89AB_CDEF_1357;
   localparam logic [79:0] IV1 = 80'hFEDC_BA98_7654_3210_2468;
   localparam logic [79:0] IV2 = 80'h5A5A_0F0F_C3C3_9696_1234;

   trivium_core #(.OUT_BITS(OUT_N)) dut (
      .CLK    (CLK),
      .RST    (RST),
      .Kin    (Kin),
      .Din    (Din),
      .Dout   (Dout),
      .Krdy   (Krdy),
      .Drdy   (Drdy),
      .EncDec (EncDec),
      .EN     (EN),
      .BSY    (BSY),
      .Kvld   (Kvld),
      .Dvld   (Dvld)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
      cyc++;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Reference Trivium written directly against the s1..s288 numbering.
   task automatic m_round(output bit z);
      bit t1;
      bit t2;
      bit t3;
      t1 = ms[66] ^ ms[93];
      t2 = ms[162] ^ ms[177];
      t3 = ms[243] ^ ms[288];
      z  = t1 ^ t2 ^ t3;
      t1 = t1 ^ (ms[91] & ms[92]) ^ ms[171];
      t2 = t2 ^ (ms[175] & ms[176]) ^ ms[264];
      t3 = t3 ^ (ms[286] & ms[287]) ^ ms[69];
      for (int i = 93; i >= 2; i--) ms[i] = ms[i-1];
      ms[1] = t3;
      for (int i = 177; i >= 95; i--) ms[i] = ms[i-1];
      ms[94] = t1;
      for (int i = 288; i >= 179; i--) ms[i] = ms[i-1];
      ms[178] = t2;
   endtask

   // Push the expected keystream for (k, iv); use_kat substitutes the
   // published first 16 bits (bytes FB E0, LSB first) for the all-zero vector.
   task automatic model_push(input logic [79:0] k, input logic [79:0] iv, input bit use_kat);
      logic [15:0] kat;
      bit z;
      kat = 16'hE0FB;
      for (int i = 1; i <= 288; i++) ms[i] = 1'b0;
      for (int i = 1; i <= 80; i++) begin
         ms[i]      = k[i-1];
         ms[93 + i] = iv[i-1];
      end
      ms[286] = 1'b1;
      ms[287] = 1'b1;
      ms[288] = 1'b1;
      for (int i = 0; i < 1152; i++) m_round(z);
      for (int i = 0; i < OUT_N; i++) begin
         m_round(z);
         if (use_kat && i < 16) z = kat[i];
         exp_q.push_back(z);
      end
   endtask

   task automatic wait_dvld(input int bound);
      for (int i = 0; i < bound && !Dvld; i++) tick();
      if (!Dvld) begin
         checks++;
         failures++;
         $display("FAIL wait_dvld: Dvld=%0b after %0d cycles, required 1", Dvld, bound);
      end
   endtask

   task automatic wait_idle(input int bound);
      for (int i = 0; i < bound && BSY; i++) tick();
      chk("wait_idle_bsy", BSY, 0);
   endtask

   // Only edges with EN=1 and no reset can produce a new keystream bit.
   always @(posedge CLK) begin
      en_q  <= EN;
      rst_q <= RST;
   end

   always @(negedge CLK) begin : monitor
      bit e;
      if (en_q && !rst_q && Dvld) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL keystream: Dvld with no expected bit, Dout=%0b", Dout);
         end else begin
            e = exp_q.pop_front();
            chk("keystream", Dout, e);
         end
      end
   end

   initial begin
      // Reset with EN low, then with EN high.
      tick();
      chk("reset_en0", {BSY, Kvld, Dvld, Dout}, 0);
      EN = 1'b1;
      tick();
      chk("reset_en1", {BSY, Kvld, Dvld, Dout}, 0);
      RST = 1'b0;

      // IV strobe without a key is ignored.
      Drdy = 1'b1;
      repeat (3) tick();
      chk("drdy_no_key_bsy", BSY, 0);
      Drdy = 1'b0;

      // Key load pulse.
      Kin  = '0;
      Krdy = 1'b1;
      tick();
      chk("kvld_pulse", Kvld, 1);
      chk("kvld_bsy", BSY, 0);
      Krdy = 1'b0;
      tick();
      chk("kvld_end", Kvld, 0);

      // All-zero key/IV: known-answer run with latency and length checks.
      model_push('0, '0, 1'b1);
      Din  = '0;
      Drdy = 1'b1;
      tick();
      acc_cyc = cyc;
      chk("bsy_rise", BSY, 1);
      Drdy = 1'b0;
      Krdy = 1'b1;
      Kin  = '1;
      repeat (3) begin
         tick();
         chk("krdy_busy_kvld", Kvld, 0);
      end
      Krdy = 1'b0;
      Kin  = '0;
      wait_dvld(2000);
      chk("first_bit_latency", cyc - acc_cyc, INIT_CYC + 1);
      n = 1;
      for (int i = 0; i < OUT_N + 10; i++) begin
         tick();
         if (!Dvld) break;
         n++;
      end
      chk("dvld_count", n, OUT_N);
      chk("bsy_end", BSY, 0);
      chk("dout_idle", Dout, 0);
      chk("queue_empty_1", exp_q.size(), 0);

      // Krdy and Drdy together: key first, IV on the following cycle.
      Kin  = K1;
      Din  = IV1;
      Krdy = 1'b1;
      Drdy = 1'b1;
      tick();
      chk("both_kvld", Kvld, 1);
      chk("both_bsy", BSY, 0);
      Krdy = 1'b0;
      model_push(K1, IV1, 1'b0);
      tick();
      chk("iv_after_key_bsy", BSY, 1);
      Drdy = 1'b0;

      // EN pauses mid-warm-up and mid-stream.
      repeat (INIT_CYC / 2) tick();
      EN = 1'b0;
      repeat (10) begin
         tick();
         chk("frozen_init", {BSY, Dvld, Dout}, 3'b100);
      end
      EN = 1'b1;
      wait_dvld(2000);
      repeat (40) tick();
      EN = 1'b0;
      repeat (10) begin
         tick();
         chk("frozen_stream", {BSY, Dvld}, 2'b11);
      end
      EN = 1'b1;
      wait_idle(500);
      chk("queue_empty_2", exp_q.size(), 0);

      // Key stays loaded: new IV alone restarts the cipher.
      Din  = IV2;
      Drdy = 1'b1;
      model_push(K1, IV2, 1'b0);
      tick();
      chk("reuse_key_bsy", BSY, 1);
      Drdy = 1'b0;
      wait_dvld(2000);
      repeat (20) tick();

      // Reset mid-stream aborts and forgets the key.
      RST = 1'b1;
      tick();
      chk("rst_mid_stream", {BSY, Kvld, Dvld, Dout}, 0);
      RST = 1'b0;
      exp_q.delete();
      Drdy = 1'b1;
      repeat (3) tick();
      chk("drdy_after_rst", BSY, 0);
      Drdy = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
